time_set_ctrl: RTL
==================

Name: time_set_ctrl

Overview:
Producer side of the counter's set-time interface: generates the ENABLE / SET_TIME pair that the seconds counter (0..3599) consumes.
- On entry to set mode, splits the live count into minutes and seconds by iterative subtraction.
- Lets the user edit one field at a time with up/down buttons, with auto-repeat.
- Holds ENABLE low for the whole session, so the counter keeps loading SET_TIME.
- Sits between the button synchronizers / mode FSM and the counter.

Parameters:
REPEAT_DELAY, 500, CLOCK cycles a button must be held before auto-repeat starts
REPEAT_RATE, 100, CLOCK cycles between auto-repeat steps
MAX_MIN, 59, highest minute value (wraps to 0)
MAX_SEC, 59, highest second value (wraps to 0)

Ports:
CLOCK  in  1  system scan clock, single clock domain
RESET_N  in  1  asynchronous active-low reset
MODE_SET  in  1  level, 1 = time-set mode requested (asynchronous, synchronized inside)
BTN_FIELD  in  1  raw debounced button, toggles the edited field
BTN_UP  in  1  raw debounced button, increments the selected field
BTN_DOWN  in  1  raw debounced button, decrements the selected field
CUR_COUNT  in  12  live counter value, 0..3599
ENABLE  out  1  to counter; 0 = counter loads SET_TIME
SET_TIME  out  12  minutes*60 + seconds, 0..3599
FIELD_SEL  out  1  1 = minutes selected, 0 = seconds selected
BUSY  out  1  high during CAPTURE
EDIT_DONE  out  1  one-cycle pulse on commit

Behaviour:
Synchronization and edges:
- All four button/mode inputs pass through 2-FF synchronizers.
- Rising/falling edges are taken from the synchronized values, so 2-cycle input latency.

Reset (RESET_N low, asynchronous) drives:
- state IDLE, ENABLE=1, SET_TIME=0, mm=0, ss=0
- FIELD_SEL=1, BUSY=0, EDIT_DONE=0, repeat counters cleared

SET_TIME:
- Registered; equals mm*60+ss, updated one cycle after mm/ss change.
- Computed as (mm<<6)-(mm<<2)+ss, 12-bit; never exceeds 3599.

States:
- IDLE: ENABLE=1. On MODE_SET rising edge: rem<=CUR_COUNT, mm<=0, SET_TIME<=CUR_COUNT, ENABLE<=0, BUSY<=1, go CAPTURE.
- CAPTURE: each cycle, if rem>=60 then rem<=rem-60 and mm<=mm+1; else ss<=rem[5:0], BUSY<=0, go EDIT.
  - Latency is floor(CUR_COUNT/60)+1 cycles (max 60).
  - SET_TIME holds the snapshot throughout. Buttons are ignored.
  - MODE_SET falling here: abort to IDLE, ENABLE<=1, SET_TIME keeps the snapshot, EDIT_DONE not pulsed.
- EDIT: ENABLE=0.
  - BTN_FIELD rising edge toggles FIELD_SEL.
  - An UP/DOWN step adjusts the selected field with wrap: 59+1->0, 0-1->59.
  - MODE_SET falling edge goes to COMMIT.
- COMMIT (1 cycle): ENABLE<=1, EDIT_DONE=1, SET_TIME unchanged, go IDLE.

Steps and auto-repeat:
- A step occurs on the press edge.
- If the button is still held REPEAT_DELAY cycles after the press, another step occurs.
- Thereafter one step every REPEAT_RATE cycles while held.
- Release clears the hold counter.

Simultaneous events:
- UP and DOWN both high: no step; hold counter cleared.
- FIELD edge in the same cycle as a step: the step applies to the old field, then the field toggles.
- MODE_SET falling in the same cycle as a step: the step is dropped, then COMMIT.

Persistence:
- FIELD_SEL persists across sessions.
- Mid-operation reset returns ENABLE=1 immediately (asynchronous).

Decomposition:
- Shared package time_pkg holds:
  - constants SEC_PER_MIN=60, MAX_COUNT=3599, COUNT_W=12
  - state enum {IDLE, CAPTURE, EDIT, COMMIT}
- One sub-module, btn_repeat: synchronizer, edge detect, and hold/repeat counter, producing a step pulse. Instantiated for UP and DOWN.
- FIELD and MODE_SET use only the sync and edge part of btn_repeat, with repeat disabled (REPEAT_DELAY=0 means no repeat).

Test Plan:
- CUR_COUNT=3599, MODE_SET rise: expect BUSY for 60 cycles, then mm=59, ss=59, SET_TIME=3599, ENABLE=0 from the first CAPTURE cycle.
- CUR_COUNT=0, enter EDIT, FIELD_SEL=1, one DOWN tap: expect mm=59 and SET_TIME=3540. Then toggle field and tap UP: expect ss=1, SET_TIME=3541.
- In EDIT with mm=10, hold UP for REPEAT_DELAY+3*REPEAT_RATE cycles: expect exactly 5 steps (press, delay, 3 repeats), mm=15, SET_TIME=900+ss.
- UP and DOWN held together for 1000 cycles: SET_TIME constant. FIELD edge coincident with an UP tap on minutes: mm+1 and FIELD_SEL=0 afterwards.
- MODE_SET falls 5 cycles into CAPTURE of CUR_COUNT=1234: expect ENABLE=1 next cycle, SET_TIME=1234, no EDIT_DONE.
- Normal exit from EDIT: expect a one-cycle EDIT_DONE, ENABLE rises the same cycle, SET_TIME stable. RESET_N low mid-EDIT: ENABLE=1 and SET_TIME=0 without a clock edge.

Source files
------------

// File: rtl/time_pkg.sv
// Shared definitions for the set-time producer: count width, time constants,
// controller states and the minutes/seconds to count conversion.
package time_pkg;

  localparam int unsigned COUNT_W     = 12;
  localparam int unsigned SEC_PER_MIN = 60;
  localparam int unsigned MAX_COUNT   = 3599;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    EDIT,
    COMMIT
  } state_e;

  // mm*60 + ss as a shift/subtract, never above 3599 for mm,ss <= 59
  function automatic logic [COUNT_W-1:0] to_set_time(input logic [5:0] mm,
                                                     input logic [5:0] ss);
    logic [COUNT_W-1:0] m;
    m = {6'd0, mm};
    return (m << 6) - (m << 2) + {6'd0, ss};
  endfunction

endpackage

// File: rtl/time_set_ctrl_btn_repeat.sv
// Button front end: 2-FF synchronizer, edge detect and hold/auto-repeat timer.
// REPEAT_DELAY = 0 disables auto-repeat, leaving a plain press-edge step.
module btn_repeat #(
  parameter int unsigned REPEAT_DELAY = 0,
  parameter int unsigned REPEAT_RATE  = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  input  logic inhibit_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic step_o
);

  localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TW   = (TMAX < 2) ? 1 : $clog2(TMAX);

  logic          sync1_q, sync2_q, prev_q;
  logic          active_q, active_d;
  logic [TW-1:0] tmr_q, tmr_d;

  assign level_o = sync2_q;
  assign rise_o  = sync2_q & ~prev_q;
  assign fall_o  = ~sync2_q & prev_q;

  // Step on the press edge, then after REPEAT_DELAY, then every REPEAT_RATE.
  // Inhibit or release drops the hold; a fresh press is needed to step again.
  always_comb begin
    active_d = active_q;
    tmr_d    = tmr_q;
    step_o   = 1'b0;
    if (!sync2_q || inhibit_i) begin
      active_d = 1'b0;
      tmr_d    = '0;
    end else if (!prev_q) begin
      step_o   = 1'b1;
      active_d = (REPEAT_DELAY != 0);
      tmr_d    = TW'(REPEAT_DELAY - 1);
    end else if (active_q) begin
      if (tmr_q == '0) begin
        step_o = 1'b1;
        tmr_d  = TW'(REPEAT_RATE - 1);
      end else begin
        tmr_d = tmr_q - TW'(1);
      end
    end
  end

  // Synchronizer, edge history and hold timer registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      active_q <= 1'b0;
      tmr_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      active_q <= active_d;
      tmr_q    <= tmr_d;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Set-time producer for the 0..3599 seconds counter: captures the live count
// as mm:ss, lets the user edit one field with up/down auto-repeat, and drives
// ENABLE low for the whole session so the counter keeps loading SET_TIME.
module time_set_ctrl
  import time_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100,
  parameter int unsigned MAX_MIN      = 59,
  parameter int unsigned MAX_SEC      = 59
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  input  logic               MODE_SET,
  input  logic               BTN_FIELD,
  input  logic               BTN_UP,
  input  logic               BTN_DOWN,
  input  logic [COUNT_W-1:0] CUR_COUNT,
  output logic               ENABLE,
  output logic [COUNT_W-1:0] SET_TIME,
  output logic               FIELD_SEL,
  output logic               BUSY,
  output logic               EDIT_DONE
);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] rem_q, rem_d;
  logic [COUNT_W-1:0] set_time_q, set_time_d;
  logic [5:0]         mm_q, mm_d, ss_q, ss_d;
  logic               enable_q, enable_d;
  logic               field_q, field_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [COUNT_W-1:0] snap;

  logic up_level, up_rise, up_fall, up_step;
  logic dn_level, dn_rise, dn_fall, dn_step;
  logic fld_level, fld_rise, fld_fall, fld_step;
  logic mode_level, mode_rise, mode_fall, mode_step;
  logic both_held;
  logic unused_ok;

  assign both_held = up_level & dn_level;
  assign unused_ok = ^{up_rise, up_fall, dn_rise, dn_fall, fld_level, fld_rise,
                       fld_fall, mode_level, mode_step};

  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_up (
    .clk_i(CLOCK), .rst_ni(RESET_N), .btn_i(BTN_UP), .inhibit_i(both_held),
    .level_o(up_level), .rise_o(up_rise), .fall_o(up_fall), .step_o(up_step));

  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_down (
    .clk_i(CLOCK), .rst_ni(RESET_N), .btn_i(BTN_DOWN), .inhibit_i(both_held),
    .level_o(dn_level), .rise_o(dn_rise), .fall_o(dn_fall), .step_o(dn_step));

  btn_repeat #(.REPEAT_DELAY(0), .REPEAT_RATE(1)) u_field (
    .clk_i(CLOCK), .rst_ni(RESET_N), .btn_i(BTN_FIELD), .inhibit_i(1'b0),
    .level_o(fld_level), .rise_o(fld_rise), .fall_o(fld_fall), .step_o(fld_step));

  btn_repeat #(.REPEAT_DELAY(0), .REPEAT_RATE(1)) u_mode (
    .clk_i(CLOCK), .rst_ni(RESET_N), .btn_i(MODE_SET), .inhibit_i(1'b0),
    .level_o(mode_level), .rise_o(mode_rise), .fall_o(mode_fall), .step_o(mode_step));

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v >= max) ? '0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] max);
    return (v == '0 || v > max) ? max : v - 6'd1;
  endfunction

  // Out-of-range counts are clamped so the capture loop cannot overflow mm
  assign snap = (CUR_COUNT > COUNT_W'(MAX_COUNT)) ? COUNT_W'(MAX_COUNT) : CUR_COUNT;

  // Session FSM: capture by repeated subtraction, edit, commit
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    set_time_d = set_time_q;
    mm_d       = mm_q;
    ss_d       = ss_q;
    enable_d   = enable_q;
    field_d    = field_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mode_rise) begin
          rem_d      = snap;
          mm_d       = '0;
          set_time_d = snap;
          enable_d   = 1'b0;
          busy_d     = 1'b1;
          state_d    = CAPTURE;
        end
      end
      CAPTURE: begin
        if (mode_fall) begin
          enable_d = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else if (rem_q >= COUNT_W'(SEC_PER_MIN)) begin
          rem_d = rem_q - COUNT_W'(SEC_PER_MIN);
          mm_d  = mm_q + 6'd1;
        end else begin
          ss_d    = rem_q[5:0];
          busy_d  = 1'b0;
          state_d = EDIT;
        end
      end
      EDIT: begin
        set_time_d = to_set_time(mm_q, ss_q);
        // ENABLE and EDIT_DONE are raised on entry so both show in the COMMIT cycle
        if (mode_fall) begin
          enable_d = 1'b1;
          done_d   = 1'b1;
          state_d  = COMMIT;
        end else begin
          if (up_step) begin
            if (field_q) mm_d = wrap_inc(mm_q, 6'(MAX_MIN));
            else         ss_d = wrap_inc(ss_q, 6'(MAX_SEC));
          end else if (dn_step) begin
            if (field_q) mm_d = wrap_dec(mm_q, 6'(MAX_MIN));
            else         ss_d = wrap_dec(ss_q, 6'(MAX_SEC));
          end
          if (fld_step) field_d = ~field_q;
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state registers
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      set_time_q <= '0;
      mm_q       <= '0;
      ss_q       <= '0;
      enable_q   <= 1'b1;
      field_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      set_time_q <= set_time_d;
      mm_q       <= mm_d;
      ss_q       <= ss_d;
      enable_q   <= enable_d;
      field_q    <= field_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ENABLE    = enable_q;
  assign SET_TIME  = set_time_q;
  assign FIELD_SEL = field_q;
  assign BUSY      = busy_q;
  assign EDIT_DONE = done_q;

endmodule
